// File: rtl/mod_hex_snapshot_ctrl_if.sv
// Signal bundle between the video/debug side and the hex snapshot controller.
// The master drives pixel position, sources and controls; the slave returns the display bytes and status.
interface mod_hex_snapshot_ctrl_if #(
  parameter int N_SRC = 4
);
  localparam int PAGE_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [64*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_valid;
  logic               page_next;
  logic               auto_cycle;
  logic               freeze;
  logic [7:0]         data0;
  logic [7:0]         data1;
  logic [7:0]         data2;
  logic [7:0]         data3;
  logic [7:0]         data4;
  logic [7:0]         data5;
  logic [7:0]         data6;
  logic [7:0]         data7;
  logic [PAGE_W-1:0]  page;
  logic               snap_done;
  logic [7:0]         miss_cnt;

  modport master (
    output pix_x, pix_y, src_data, src_valid, page_next, auto_cycle, freeze,
    input  data0, data1, data2, data3, data4, data5, data6, data7,
    input  page, snap_done, miss_cnt
  );

  modport slave (
    input  pix_x, pix_y, src_data, src_valid, page_next, auto_cycle, freeze,
    output data0, data1, data2, data3, data4, data5, data6, data7,
    output page, snap_done, miss_cnt
  );
endinterface

// File: rtl/mod_hex_snapshot_ctrl.sv
// Frame-synchronous snapshot controller for the hex debug overlay: captures one 64-bit
// source byte-serially into a shadow buffer once per frame and commits all 8 bytes at once.
module mod_hex_snapshot_ctrl #(
  parameter int         N_SRC       = 4,
  parameter logic [9:0] FRAME_LINE  = 10'd480,
  parameter int         AUTO_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_hex_snapshot_ctrl_if.slave bus
);
  localparam int PAGE_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic              match, match_q, trig;
  logic [7:0]        frame_q;
  logic              frame_wrap, auto_adv, advance;
  logic [PAGE_W-1:0] page_q, cap_src;
  logic [2:0]        idx_q;
  logic [63:0]       shadow_q, data_q;
  logic              snap_q;
  logic [7:0]        miss_q;
  logic              start, shift, commit, miss;
  logic [63:0]       src_words [N_SRC];
  logic [63:0]       cap_word;

  // A trigger is the first edge of the capture-line condition, however long it is held.
  assign match      = (bus.pix_x == 10'd0) && (bus.pix_y == FRAME_LINE);
  assign trig       = match && !match_q;
  assign frame_wrap = (frame_q == 8'(AUTO_FRAMES - 1));
  assign auto_adv   = trig && frame_wrap && bus.auto_cycle && !bus.freeze;
  assign advance    = bus.page_next || auto_adv;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_words[i] = bus.src_data[64*i +: 64];
    end
  end

  assign cap_word = src_words[cap_src];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    miss    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig && !bus.freeze) begin
          if (bus.src_valid[page_q]) begin
            start   = 1'b1;
            state_d = CAPTURE;
          end else begin
            miss = 1'b1;
          end
        end
      end
      CAPTURE: begin
        shift = 1'b1;
        if (idx_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, which is
  // exactly why cap_src takes the old page when an advance lands on the trigger edge.
  // NOTE: the shadow buffer is reset with everything else so a reset leaves no stale bytes behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q  <= 1'b0;
      frame_q  <= 8'd0;
      page_q   <= '0;
      cap_src  <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 64'd0;
      data_q   <= 64'd0;
      snap_q   <= 1'b0;
      miss_q   <= 8'd0;
    end else begin
      match_q <= match;
      snap_q  <= commit;

      if (trig) frame_q <= frame_wrap ? 8'd0 : frame_q + 8'd1;

      // Concurrent manual and timed requests collapse into a single step.
      if (advance) page_q <= (page_q == PAGE_W'(N_SRC - 1)) ? '0 : page_q + 1'b1;

      if (start) begin
        cap_src <= page_q;
        idx_q   <= 3'd0;
      end

      // Byte idx sits at the idx-th byte from the top of the 64-bit word.
      if (shift) begin
        shadow_q[{~idx_q, 3'b000} +: 8] <= cap_word[{~idx_q, 3'b000} +: 8];
        idx_q                           <= idx_q + 3'd1;
      end

      if (commit) data_q <= shadow_q;

      if (miss && (miss_q != 8'hFF)) miss_q <= miss_q + 8'd1;
    end
  end

  assign bus.data0     = data_q[63:56];
  assign bus.data1     = data_q[55:48];
  assign bus.data2     = data_q[47:40];
  assign bus.data3     = data_q[39:32];
  assign bus.data4     = data_q[31:24];
  assign bus.data5     = data_q[23:16];
  assign bus.data6     = data_q[15:8];
  assign bus.data7     = data_q[7:0];
  assign bus.page      = page_q;
  assign bus.snap_done = snap_q;
  assign bus.miss_cnt  = miss_q;
endmodule

// File: tb/tb_mod_hex_snapshot_ctrl.sv
// Directed bench for mod_hex_snapshot_ctrl: a default instance (4 sources, 60 frames/page)
// and a small one (3 sources, 2 frames/page) for the auto-cycle sequence.
module tb_mod_hex_snapshot_ctrl;
  logic clk;
  logic reset;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   snap_a    = 0;
  int   snap_cyc_a = 0;

  mod_hex_snapshot_ctrl_if #(.N_SRC(4)) bus_a ();
  mod_hex_snapshot_ctrl_if #(.N_SRC(3)) bus_b ();

  mod_hex_snapshot_ctrl #(.N_SRC(4), .FRAME_LINE(10'd480), .AUTO_FRAMES(60)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  mod_hex_snapshot_ctrl #(.N_SRC(3), .FRAME_LINE(10'd480), .AUTO_FRAMES(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic [63:0] disp_a;
  assign disp_a = {bus_a.data0, bus_a.data1, bus_a.data2, bus_a.data3,
                   bus_a.data4, bus_a.data5, bus_a.data6, bus_a.data7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot pulses are counted and time-stamped away from the active edge.
  always @(negedge clk) begin
    if (bus_a.snap_done === 1'b1) begin
      snap_a     <= snap_a + 1;
      snap_cyc_a <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the capture-line condition for 'hold' edges; optional page_next on the first edge.
  task automatic trig_a(input int hold, input logic pn, output int m);
    @(negedge clk);
    m = cyc;
    bus_a.pix_x     = 10'd0;
    bus_a.pix_y     = 10'd480;
    bus_a.page_next = pn;
    @(negedge clk);
    bus_a.page_next = 1'b0;
    repeat (hold - 1) @(negedge clk);
    bus_a.pix_x = 10'd1;
    bus_a.pix_y = 10'd0;
  endtask

  task automatic trig_b(input logic pn);
    @(negedge clk);
    bus_b.pix_x     = 10'd0;
    bus_b.pix_y     = 10'd480;
    bus_b.page_next = pn;
    @(negedge clk);
    bus_b.page_next = 1'b0;
    @(negedge clk);
    bus_b.pix_x = 10'd1;
    bus_b.pix_y = 10'd0;
    wait_cycles(2);
  endtask

  int m;
  int snap_before;
  int exp_pg [6] = '{0, 1, 1, 2, 2, 0};

  initial begin
    bus_a.pix_x = 10'd1;  bus_a.pix_y = 10'd0;  bus_a.src_data = '0; bus_a.src_valid = '0;
    bus_a.page_next = 1'b0; bus_a.auto_cycle = 1'b0; bus_a.freeze = 1'b0;
    bus_b.pix_x = 10'd1;  bus_b.pix_y = 10'd0;  bus_b.src_data = '0; bus_b.src_valid = '0;
    bus_b.page_next = 1'b0; bus_b.auto_cycle = 1'b0; bus_b.freeze = 1'b0;
    reset = 1'b1;
    wait_cycles(3);
    check("reset_data", disp_a, 64'd0);
    check("reset_page", bus_a.page, 0);
    check("reset_miss", bus_a.miss_cnt, 0);
    check("reset_snap", bus_a.snap_done, 0);
    reset = 1'b0;
    wait_cycles(2);

    // Basic capture: trigger held 4 cycles gives exactly one snapshot 9 edges later.
    bus_a.src_data[63:0] = 64'h0123456789ABCDEF;
    bus_a.src_valid      = 4'b0001;
    trig_a(4, 1'b0, m);
    wait_cycles(12);
    check("cap0_snap_count", snap_a, 1);
    check("cap0_latency", snap_cyc_a, m + 10);
    check("cap0_data", disp_a, 64'h0123456789ABCDEF);
    check("cap0_page", bus_a.page, 0);

    // Invalid source: misses counted, outputs untouched, counter saturates.
    bus_a.src_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      trig_a(4, 1'b0, m);
      wait_cycles(12);
    end
    check("miss3_snap_count", snap_a, 1);
    check("miss3_data", disp_a, 64'h0123456789ABCDEF);
    check("miss3_cnt", bus_a.miss_cnt, 3);
    for (int i = 0; i < 297; i++) begin
      trig_a(1, 1'b0, m);
      wait_cycles(2);
    end
    check("miss_sat", bus_a.miss_cnt, 255);

    // page_next on the trigger edge: this frame still captures source 0.
    bus_a.src_data[63:0]   = 64'h8899AABBCCDDEEFF;
    bus_a.src_data[127:64] = 64'hFFEEDDCCBBAA9988;
    bus_a.src_valid        = 4'b0011;
    trig_a(4, 1'b1, m);
    wait_cycles(12);
    check("adv_old_page_data", disp_a, 64'h8899AABBCCDDEEFF);
    check("adv_page", bus_a.page, 1);
    check("adv_snap_count", snap_a, 2);
    trig_a(4, 1'b0, m);
    wait_cycles(12);
    check("adv_new_page_data", disp_a, 64'hFFEEDDCCBBAA9988);

    // Source changes at S+3, reset asserted mid-capture.
    @(negedge clk);
    bus_a.pix_x = 10'd0;
    bus_a.pix_y = 10'd480;
    wait_cycles(3);
    bus_a.src_data[127:64] = 64'h1111111111111111;
    bus_a.src_valid        = 4'b0001;
    @(negedge clk);
    bus_a.pix_x = 10'd1;
    bus_a.pix_y = 10'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_data", disp_a, 64'd0);
    check("rst_mid_page", bus_a.page, 0);
    check("rst_mid_miss", bus_a.miss_cnt, 0);
    reset = 1'b0;
    snap_before = snap_a;
    wait_cycles(12);
    check("rst_mid_no_snap", snap_a, snap_before);
    check("rst_mid_data_after", disp_a, 64'd0);
    trig_a(4, 1'b0, m);
    wait_cycles(12);
    check("rst_recover_data", disp_a, 64'h8899AABBCCDDEEFF);
    check("rst_recover_snap", snap_a, snap_before + 1);

    // Freeze: no capture, no miss, page_next still honoured.
    bus_a.freeze          = 1'b1;
    bus_a.src_data[63:0]  = 64'h5555555555555555;
    bus_a.src_valid       = 4'b0000;
    snap_before           = snap_a;
    trig_a(4, 1'b0, m);
    wait_cycles(12);
    check("frz_no_snap", snap_a, snap_before);
    check("frz_data_held", disp_a, 64'h8899AABBCCDDEEFF);
    check("frz_no_miss", bus_a.miss_cnt, 0);
    @(negedge clk);
    bus_a.page_next = 1'b1;
    @(negedge clk);
    bus_a.page_next = 1'b0;
    @(negedge clk);
    check("frz_page_next", bus_a.page, 1);

    // Freeze rising at S+4 does not abort the capture in flight.
    bus_a.freeze           = 1'b0;
    bus_a.src_data[127:64] = 64'h0F1E2D3C4B5A6978;
    bus_a.src_valid        = 4'b0010;
    snap_before            = snap_a;
    @(negedge clk);
    m = cyc;
    bus_a.pix_x = 10'd0;
    bus_a.pix_y = 10'd480;
    wait_cycles(4);
    bus_a.pix_x  = 10'd1;
    bus_a.pix_y  = 10'd0;
    bus_a.freeze = 1'b1;
    wait_cycles(10);
    check("frz_mid_snap", snap_a, snap_before + 1);
    check("frz_mid_latency", snap_cyc_a, m + 10);
    check("frz_mid_data", disp_a, 64'h0F1E2D3C4B5A6978);
    bus_a.freeze = 1'b0;

    // Auto-cycle on the 3-source, 2-frame instance.
    bus_b.auto_cycle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      trig_b(1'b0);
      check($sformatf("auto_page_%0d", i + 1), bus_b.page, exp_pg[i]);
    end
    trig_b(1'b0);
    trig_b(1'b1);
    check("auto_plus_next_one_step", bus_b.page, 1);
    bus_b.freeze = 1'b1;
    trig_b(1'b0);
    trig_b(1'b0);
    trig_b(1'b0);
    check("auto_frz_page", bus_b.page, 1);
    check("auto_frz_miss", bus_b.miss_cnt, 8);
    bus_b.freeze = 1'b0;
    trig_b(1'b0);
    check("auto_count_in_freeze", bus_b.page, 2);
    check("auto_miss_after", bus_b.miss_cnt, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
